mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle control sequencer for the MIPS datapath: a state machine that splits each instruction into fetch, decode, execute, memory and writeback steps.
- It drives all datapath select and enable lines, waits on a shared instruction/data memory through a ready handshake, counts retired instructions, and traps on illegal opcodes and memory timeouts.
- It replaces the single-cycle combinational control unit when the datapath shares one ALU and one memory port.

Parameters:
COUNT_W, 32, width of the retired-instruction counter
TIMEOUT, 255, maximum cycles spent waiting for memReady in one memory state; 0 disables the watchdog

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
opcode  input  6  instr[31:26] from the instruction register
memReady  input  1  memory has completed the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by the datapath zero flag (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data select: 1 = memory data register
RegDst  output  1  destination select: 1 = rd, 0 = rt
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = Rs
ALUSrcB  output  2  ALU operand B select: 00 = Rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
ALUOp  output  2  ALU operation: 00 = add, 01 = subtract, 10 = decode from funct field
PCSource  output  2  PC next select: 00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state, for debug
instrCount  output  COUNT_W  number of instructions fetched
illegalOp  output  1  sticky flag: undecodable opcode
memError  output  1  sticky flag: memory watchdog expired

Behaviour:
- Reset is synchronous and active-high, on a single clock clk. On a clock edge with rst=1:
  - state returns to FETCH (0); instrCount, illegalOp, memError and the watchdog counter clear.
  - This applies in any state, including in the middle of a memory wait.
- While rst=1, every control output is forced to 0, so no memory, register or PC write can occur.
- All control outputs are Moore outputs decoded from state. Any signal not listed for a state is 0.
- Opcodes decoded: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States, outputs and transitions:
  - 0 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=1 and PCWrite=1 only while memReady=1. When memReady=1, go to DECODE and increment instrCount (wraps modulo 2^COUNT_W); otherwise stay.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
    - lw or sw go to MEMADR; R-type goes to EXEC; beq goes to BRANCH; j goes to JUMP; addi goes to ADDIEX.
    - Any other opcode goes to ILLEGAL.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw goes to MEMRD; sw goes to MEMWR.
  - 3 MEMRD: MemRead=1, IorD=1. When memReady=1 go to MEMWB; otherwise wait.
  - 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then go to FETCH.
  - 5 MEMWR: MemWrite=1, IorD=1. When memReady=1 go to FETCH; otherwise wait.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
  - 7 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then go to FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
  - 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
  - 10 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then go to FETCH.
  - 11 JUMP: PCWrite=1, PCSource=10, then go to FETCH.
  - 12 ILLEGAL: all control outputs 0; illegalOp=1; remains here until reset.
  - 13 MEMERR: all control outputs 0; memError=1; remains here until reset.
  - Codes 14 and 15 are unreachable; if entered, go to FETCH on the next edge.
- Instruction latency with memReady tied to 1:
  - lw: 5 cycles; sw: 4; R-type: 4; addi: 4; beq: 3; j: 3.
  - Each cycle of memReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Watchdog:
  - The counter clears on entry to each of FETCH, MEMRD and MEMWR.
  - It increments on every cycle spent in those states with memReady=0.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT while memReady is still 0, the next state is MEMERR instead of staying.
  - If memReady=1 arrives on the same cycle the counter reaches TIMEOUT, the access completes normally; memReady wins.
- opcode is sampled only in DECODE and MEMADR; changes in other states have no effect.
- memReady is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Reset, then memReady=1 and opcode=000000 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. instrCount=1 after the DECODE entry edge.
- lw (100011) with memReady low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. IorD=1 and MemRead=1 throughout state 3. MemtoReg=1 and RegWrite=1 in state 4.
- beq (000100) then j (000010) -> BRANCH asserts PCWriteCond=1, PCSource=01, ALUOp=01. JUMP asserts PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- opcode=111111 -> state 12, illegalOp=1, held for 20 cycles. Assert rst for one cycle -> state=0, illegalOp=0, instrCount=0.
- TIMEOUT=4, memReady=0 in MEMWR -> MEMERR reached after 4 wait cycles, memError=1. Repeat with memReady=1 on the 4th wait cycle -> FETCH, memError stays 0.
- Assert rst in the middle of MEMRD -> all control outputs are 0 during the rst cycle, and state=0 on the next edge.

Source files
------------

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control bus between the multi-cycle sequencer and the MIPS datapath
interface mc_control_if #(
    parameter int COUNT_W = 32
);
    logic [5:0]         opcode;
    logic               memReady;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic [3:0]         state;
    logic [COUNT_W-1:0] instrCount;
    logic               illegalOp;
    logic               memError;

    modport master (
        input  opcode, memReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instrCount, illegalOp, memError
    );

    modport slave (
        output opcode, memReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instrCount, illegalOp, memError
    );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control sequencer with memory watchdog
module mc_control #(
    parameter int COUNT_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mc_control_if.master bus
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value on the last tolerated wait cycle; a miss here traps.
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12,
        S_MEMERR  = 4'd13
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               in_wait;
    logic               wd_expire;

    // States that block on the shared memory and are guarded by the watchdog
    assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // memReady wins over an expiring counter on the same cycle
    assign wd_expire = (TIMEOUT != 0) && in_wait && !bus.memReady && (wd_q == WD_LAST);

    // State, instruction counter and watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state selection; opcode only matters in DECODE and MEMADR
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.memReady)   state_d = S_DECODE;
                else if (wd_expire) state_d = S_MEMERR;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.memReady)   state_d = S_MEMWB;
                else if (wd_expire) state_d = S_MEMERR;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                if (bus.memReady)   state_d = S_FETCH;
                else if (wd_expire) state_d = S_MEMERR;
            end
            S_EXEC:    state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            S_MEMERR:  state_d = S_MEMERR;
            default:   state_d = S_FETCH;
        endcase
    end

    // Retired-instruction count and watchdog; the watchdog restarts whenever the state changes
    always_comb begin
        count_d = count_q;
        wd_d    = '0;
        if ((state_q == S_FETCH) && bus.memReady) count_d = count_q + COUNT_W'(1);
        if (in_wait && !bus.memReady && (state_d == state_q)) wd_d = wd_q + WD_W'(1);
    end

    // Moore control decode, forced quiet while reset is held
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.memReady;
                    bus.PCWrite = bus.memReady;
                end
                S_DECODE: bus.ALUSrcB = 2'b11;
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                end
                S_ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_ADDIWB: bus.RegWrite = 1'b1;
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.instrCount = count_q;
    assign bus.illegalOp  = (state_q == S_ILLEGAL);
    assign bus.memError   = (state_q == S_MEMERR);
endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control
module tb_mc_control;
    localparam int CW = 8;
    localparam int TO = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cnt;
    int   exp_st[$];
    bit   drv_rd[$];

    mc_control_if #(.COUNT_W(CW)) bus ();

    mc_control #(.COUNT_W(CW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] obs_ctrl();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource};
    endfunction

    // Field order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource
    function automatic logic [15:0] exp_ctrl(input int s, input bit r);
        case (s)
            0:  return {r, 1'b0, 1'b0, 1'b1, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
            1:  return {10'b0, 2'b11, 2'b00, 2'b00};
            2:  return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            3:  return {2'b00, 1'b1, 1'b1, 12'b0};
            4:  return {6'b0, 1'b1, 1'b0, 1'b1, 7'b0};
            5:  return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
            6:  return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            7:  return {7'b0, 1'b1, 1'b1, 7'b0};
            8:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            9:  return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            10: return {8'b0, 1'b1, 7'b0};
            11: return {1'b1, 13'b0, 2'b10};
            default: return 16'h0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
    endfunction

    task automatic add_cyc(input int s, input bit r);
        exp_st.push_back(s);
        drv_rd.push_back(r);
    endtask

    // z cycles of memReady=0 before the access completes, unless the watchdog fires first
    task automatic add_wait(input int s, input int z, output bit err);
        err = 1'b0;
        if (TO != 0 && z >= TO) begin
            repeat (TO) add_cyc(s, 1'b0);
            add_cyc(13, 1'($urandom));
            err = 1'b1;
        end else begin
            repeat (z) add_cyc(s, 1'b0);
            add_cyc(s, 1'b1);
        end
    endtask

    task automatic build_trace(input logic [5:0] op, input int fz, input int mz);
        bit err;
        exp_st.delete();
        drv_rd.delete();
        add_wait(0, fz, err);
        if (!err) begin
            add_cyc(1, 1'($urandom));
            case (op)
                OP_R:    begin add_cyc(6, 1'($urandom)); add_cyc(7, 1'($urandom)); end
                OP_LW:   begin
                    add_cyc(2, 1'($urandom));
                    add_wait(3, mz, err);
                    if (!err) add_cyc(4, 1'($urandom));
                end
                OP_SW:   begin add_cyc(2, 1'($urandom)); add_wait(5, mz, err); end
                OP_BEQ:  add_cyc(8, 1'($urandom));
                OP_J:    add_cyc(11, 1'($urandom));
                OP_ADDI: begin add_cyc(9, 1'($urandom)); add_cyc(10, 1'($urandom)); end
                default: add_cyc(12, 1'($urandom));
            endcase
        end
    endtask

    task automatic check_cycle(input int s, input bit r);
        chk("state", 32'(bus.state), 32'(s));
        chk("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(s, r)));
        chk("instrCount", 32'(bus.instrCount), 32'(cnt));
        chk("illegalOp", 32'(bus.illegalOp), 32'(s == 12));
        chk("memError", 32'(bus.memError), 32'(s == 13));
    endtask

    // Entered and left at a falling edge
    task automatic exec_trace(input logic [5:0] op, input int limit);
        for (int i = 0; i < exp_st.size() && i < limit; i++) begin
            bus.memReady = drv_rd[i];
            bus.opcode   = (exp_st[i] == 1 || exp_st[i] == 2) ? op : 6'($urandom);
            #1;
            check_cycle(exp_st[i], drv_rd[i]);
            @(posedge clk);
            if (exp_st[i] == 0 && drv_rd[i]) cnt = (cnt + 1) % (1 << CW);
            @(negedge clk);
        end
    endtask

    task automatic hold_term(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            bus.memReady = 1'($urandom);
            bus.opcode   = 6'($urandom);
            #1;
            check_cycle(s, bus.memReady);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.memReady = 1'($urandom);
        bus.opcode   = 6'($urandom);
        #1;
        chk("rst_ctrl", 32'(obs_ctrl()), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_count", 32'(bus.instrCount), 32'd0);
        chk("rst_illegal", 32'(bus.illegalOp), 32'd0);
        chk("rst_memerr", 32'(bus.memError), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
    endtask

    task automatic run(input logic [5:0] op, input int fz, input int mz);
        build_trace(op, fz, mz);
        exec_trace(op, exp_st.size());
        if (exp_st[exp_st.size() - 1] >= 12) begin
            hold_term(exp_st[exp_st.size() - 1], 3);
            do_reset();
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] o;
        case ($urandom_range(0, 12) % 7)
            0: o = OP_R;
            1: o = OP_LW;
            2: o = OP_SW;
            3: o = OP_BEQ;
            4: o = OP_J;
            5: o = OP_ADDI;
            default: begin
                o = 6'($urandom);
                while (is_legal(o)) o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    function automatic int pick_wait();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
    endfunction

    initial begin
        checks       = 0;
        errors       = 0;
        cnt          = 0;
        rst          = 1'b1;
        bus.memReady = 1'b0;
        bus.opcode   = 6'b0;
        @(negedge clk);
        do_reset();

        run(OP_R, 0, 0);
        run(OP_LW, 0, 3);
        run(OP_BEQ, 0, 0);
        run(OP_J, 0, 0);
        run(OP_ADDI, 2, 0);
        run(OP_SW, 1, 0);

        build_trace(6'b111111, 0, 0);
        exec_trace(6'b111111, exp_st.size());
        hold_term(12, 20);
        do_reset();

        run(OP_SW, 0, 4);
        run(OP_SW, 0, 3);
        run(OP_R, 0, 0);
        run(OP_LW, 3, 0);
        run(OP_R, 4, 0);

        build_trace(OP_LW, 0, 3);
        exec_trace(OP_LW, 5);
        chk("mid_memrd_state", 32'(bus.state), 32'd3);
        do_reset();

        for (int i = 0; i < 260; i++) run(OP_J, 0, 0);
        chk("count_wrap", 32'(bus.instrCount), 32'd4);

        for (int i = 0; i < 200; i++) run(pick_op(), pick_wait(), pick_wait());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
